// File: rtl/eth_domain_seq_if.sv
// Control/status bundle between the SoC register block and the Ethernet domain sequencer.
// Purely wires: no storage, so it adds no latency.
// Carries no backpressure; the isolation acknowledge is the only feedback signal.
interface eth_domain_seq_if;
  logic       domain_en_i;
  logic       err_clr_i;
  logic       axi_isolated_i;
  logic       clk_en_o;
  logic       domain_rst_no;
  logic       axi_isolate_o;
  logic       active_o;
  logic       err_o;
  logic [2:0] state_o;

  // The sequencer consumes requests and acknowledge, and drives the domain controls.
  modport slave (
    input  domain_en_i, err_clr_i, axi_isolated_i,
    output clk_en_o, domain_rst_no, axi_isolate_o, active_o, err_o, state_o
  );

  // Register block / domain wrapper side.
  modport master (
    output domain_en_i, err_clr_i, axi_isolated_i,
    input  clk_en_o, domain_rst_no, axi_isolate_o, active_o, err_o, state_o
  );
endinterface

// File: rtl/eth_domain_seq.sv
// Power/isolation sequencer: clock enable, domain reset and AXI isolation in a fixed order.
// Latency: outputs decode from registered state, one edge after the deciding input is sampled.
// No backpressure; a bus that never drains times out into ERR, recovered by a forced reset.
module eth_domain_seq #(
  parameter int SettleCycles  = 8,
  parameter int RstCycles     = 16,
  parameter int TimeoutCycles = 1024
) (
  input logic            clk_i,
  input logic            rst_ni,
  eth_domain_seq_if.slave ctl
);

  localparam int MaxCycles = (SettleCycles > RstCycles)
                           ? ((SettleCycles > TimeoutCycles) ? SettleCycles : TimeoutCycles)
                           : ((RstCycles > TimeoutCycles) ? RstCycles : TimeoutCycles);
  localparam int CntWidth  = $clog2(MaxCycles) + 1;

  localparam logic [CntWidth-1:0] SettleLoad  = CntWidth'(SettleCycles - 1);
  localparam logic [CntWidth-1:0] RstLoad     = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] TimeoutLoad = CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] CntOne      = CntWidth'(1);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_CLK_ON     = 3'd1,
    S_RST_REL    = 3'd2,
    S_DEISO      = 3'd3,
    S_ON         = 3'd4,
    S_ISO_REQ    = 3'd5,
    S_RST_ASSERT = 3'd6,
    S_ERR        = 3'd7
  } state_t;

  state_t              state, state_nxt;
  logic [CntWidth-1:0] cnt, cnt_nxt;
  logic                err, err_nxt;
  logic                cnt_zero;

  assign cnt_zero = (cnt == '0);

  // State, shared down-counter and sticky error; reset gates and resets the domain at once.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_OFF;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Next state: the counter is reloaded on entry to each timed state and otherwise
  // counts down, saturating at zero. An ack on the timeout cycle counts as success.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? '0 : (cnt - CntOne);
    err_nxt   = err;
    unique case (state)
      S_OFF: begin
        if (ctl.domain_en_i) begin
          state_nxt = S_CLK_ON;
          cnt_nxt   = SettleLoad;
        end
      end
      S_CLK_ON: begin
        if (cnt_zero) begin
          state_nxt = S_RST_REL;
          cnt_nxt   = RstLoad;
        end
      end
      S_RST_REL: begin
        if (cnt_zero) begin
          state_nxt = S_DEISO;
          cnt_nxt   = TimeoutLoad;
        end
      end
      S_DEISO: begin
        if (!ctl.axi_isolated_i) begin
          state_nxt = S_ON;
          cnt_nxt   = '0;
        end else if (cnt_zero) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end
      end
      S_ON: begin
        if (!ctl.domain_en_i) begin
          state_nxt = S_ISO_REQ;
          cnt_nxt   = TimeoutLoad;
        end
      end
      S_ISO_REQ: begin
        if (ctl.axi_isolated_i) begin
          state_nxt = S_RST_ASSERT;
          cnt_nxt   = RstLoad;
        end else if (cnt_zero) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end
      end
      S_RST_ASSERT: begin
        if (cnt_zero) begin
          state_nxt = S_OFF;
        end
      end
      S_ERR: begin
        if (ctl.err_clr_i) begin
          state_nxt = S_RST_ASSERT;
          cnt_nxt   = RstLoad;
          err_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = S_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Domain controls decode purely from the registered state.
  always_comb begin
    ctl.clk_en_o      = 1'b1;
    ctl.domain_rst_no = 1'b1;
    ctl.axi_isolate_o = 1'b1;
    unique case (state)
      S_OFF:        begin ctl.clk_en_o = 1'b0; ctl.domain_rst_no = 1'b0; end
      S_CLK_ON:     ctl.domain_rst_no = 1'b0;
      S_DEISO:      ctl.axi_isolate_o = 1'b0;
      S_ON:         ctl.axi_isolate_o = 1'b0;
      S_RST_ASSERT: ctl.domain_rst_no = 1'b0;
      default:      ctl.clk_en_o = 1'b1;
    endcase
  end

  assign ctl.active_o = (state == S_ON);
  assign ctl.err_o    = err;
  assign ctl.state_o  = state;

endmodule

// File: tb/tb_eth_domain_seq.sv
// Bench for eth_domain_seq: directed and randomized power-up/down, timeout and reset scenarios.
// Expected outputs come from per-scenario timing arithmetic plus the per-state output table.
// Inputs change 1 time unit after each rising edge; outputs are compared at the same point.
module tb_eth_domain_seq;
  localparam int S = 4;
  localparam int R = 8;
  localparam int T = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  eth_domain_seq_if ifc();

  eth_domain_seq #(.SettleCycles(S), .RstCycles(R), .TimeoutCycles(T)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .ctl   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Expected {clk_en, rst_n, isolate, active, err, state[2:0]} for a state/error pair.
  function automatic logic [8:0] model(input int st, input bit e);
    logic [2:0] o;
    case (st)
      0:       o = 3'b001;
      1:       o = 3'b101;
      2:       o = 3'b111;
      3:       o = 3'b110;
      4:       o = 3'b110;
      5:       o = 3'b111;
      6:       o = 3'b101;
      default: o = 3'b111;
    endcase
    return {o, (st == 4), e, 3'(st)};
  endfunction

  task automatic step(input logic en, input logic clr, input logic ack, input logic rst);
    ifc.domain_en_i    = en;
    ifc.err_clr_i      = clr;
    ifc.axi_isolated_i = ack;
    rst_n              = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int st, input bit e);
    logic [8:0] got, exp;
    got = {ifc.clk_en_o, ifc.domain_rst_no, ifc.axi_isolate_o, ifc.active_o, ifc.err_o, ifc.state_o};
    exp = model(st, e);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // From OFF: enable at k=0; ack drops at edge 12+d (d=1..T), or never (d=0 -> ERR, cleared at clr_at).
  task automatic power_up(input int d, input int clr_at);
    int ack_edge = S + R + d;
    int err_edge = S + R + T;
    int last = (d != 0) ? ack_edge + 2 : clr_at + R + 2;
    for (int k = 0; k <= last; k++) begin
      logic en, clr, ack;
      int st;
      bit e = 1'b0;
      if (d != 0) begin
        en  = (k == 0 || k > ack_edge) ? 1'b1 : rbit();
        ack = (k >= ack_edge) ? 1'b0 : 1'b1;
        clr = rbit();
        st  = (k < S) ? 1 : (k < S + R) ? 2 : (k < ack_edge) ? 3 : 4;
      end else begin
        en  = (k == 0) ? 1'b1 : (k <= clr_at + R) ? rbit() : 1'b0;
        ack = 1'b1;
        clr = (k == clr_at) ? 1'b1 : (k >= err_edge && k < clr_at) ? 1'b0 : rbit();
        st  = (k < S) ? 1 : (k < S + R) ? 2 : (k < err_edge) ? 3 :
              (k < clr_at) ? 7 : (k < clr_at + R) ? 6 : 0;
        e   = (k >= err_edge && k < clr_at);
      end
      step(en, clr, ack, 1'b1);
      check(d != 0 ? "power_up" : "deiso_timeout", st, e);
    end
  endtask

  // From ON: disable at k=0; ack rises at edge a (a=1..T), or never (a=0 -> ERR, cleared at clr_at).
  task automatic power_down(input int a, input int clr_at);
    int last = (a != 0) ? a + R + 2 : clr_at + R + 2;
    for (int k = 0; k <= last; k++) begin
      logic en, clr, ack;
      int st;
      bit e = 1'b0;
      if (a != 0) begin
        en  = (k == 0) ? 1'b0 : (k <= a + R) ? rbit() : 1'b0;
        ack = (k >= a) ? 1'b1 : 1'b0;
        clr = rbit();
        st  = (k < a) ? 5 : (k < a + R) ? 6 : 0;
      end else begin
        en  = (k == 0) ? 1'b0 : (k <= clr_at + R) ? rbit() : 1'b0;
        ack = 1'b0;
        clr = (k == clr_at) ? 1'b1 : (k >= T && k < clr_at) ? 1'b0 : rbit();
        st  = (k < T) ? 5 : (k < clr_at) ? 7 : (k < clr_at + R) ? 6 : 0;
        e   = (k >= T && k < clr_at);
      end
      step(en, clr, ack, 1'b1);
      check(a != 0 ? "power_down" : "drain_timeout", st, e);
    end
  endtask

  initial begin
    ifc.domain_en_i    = 1'b0;
    ifc.err_clr_i      = 1'b0;
    ifc.axi_isolated_i = 1'b1;

    // Reset with random inputs.
    for (int k = 0; k < 3; k++) begin
      step(rbit(), rbit(), rbit(), 1'b0);
      check("reset", 0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("idle_off", 0, 1'b0);

    // Directed scenarios.
    power_up(3, 0);
    power_down(5, 0);
    power_up(3, 0);
    power_down(0, 20);
    power_up(16, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_in_on", 4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_in_on_hold", 4, 1'b0);
    power_down(T, 0);
    power_up(0, S + R + T + 3);

    // Reset while in ERR.
    power_up(1, 0);
    for (int k = 0; k <= T + 2; k++) begin
      step(1'b0, 1'b0, 1'b0, (k == T + 2) ? 1'b0 : 1'b1);
      check("rst_in_err", (k < T) ? 5 : (k < T + 2) ? 7 : 0, (k >= T && k < T + 2));
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("after_err_rst", 0, 1'b0);

    // Enable toggled during CLK_ON, then reset during RST_REL.
    for (int k = 0; k <= 7; k++) begin
      step((k == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1, (k == 6) ? 1'b0 : 1'b1);
      check("mid_seq", (k < S) ? 1 : (k < 6) ? 2 : 0, 1'b0);
    end

    // Randomized sequences.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        power_up(0, S + R + T + int'($urandom_range(1, 6)));
      end else begin
        power_up(int'($urandom_range(1, T)), 0);
        if ($urandom_range(0, 2) == 0) power_down(0, T + int'($urandom_range(1, 8)));
        else                           power_down(int'($urandom_range(1, T)), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
